// File: rtl/mac_share_sched.sv
// Round-robin time-sharing of one external 3-stage multiply-add DSP among N_REQ requesters.
// Each in-flight operation is tagged with its requester id. Backpressure freezes the DSP via mac_ce.
module mac_share_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MAC_LAT = 3,
  parameter int C_SKEW  = 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [27*N_REQ-1:0]  req_a,
  input  logic [18*N_REQ-1:0]  req_b,
  input  logic [48*N_REQ-1:0]  req_c,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [47:0]          res_data,
  output logic                 mac_ce,
  output logic [26:0]          mac_a,
  output logic [17:0]          mac_b,
  output logic [47:0]          mac_c,
  input  logic [47:0]          mac_dout,
  output logic                 busy
);

  logic                 stall;
  logic [ID_W-1:0]      rr_ptr_reg;
  logic                 grant_any;
  logic [ID_W-1:0]      grant_idx;
  logic [N_REQ-1:0]     grant;
  logic [26:0]          a_sel;
  logic [17:0]          b_sel;
  logic [47:0]          c_sel;
  logic [47:0]          c_dly_reg [C_SKEW];
  logic [MAC_LAT-1:0]   vld_reg;
  logic [ID_W-1:0]      id_reg    [MAC_LAT];

  // (base + off) mod N_REQ without requiring N_REQ to be a power of two
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[ID_W-1:0];
  endfunction

  assign stall  = vld_reg[MAC_LAT-1] & ~res_ready;
  assign mac_ce = ~stall;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    if (!stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!grant_any && req_valid[wrap_add(rr_ptr_reg, k)]) begin
          grant_any = 1'b1;
          grant_idx = wrap_add(rr_ptr_reg, k);
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;

  // AND-OR operand select; a bubble drives zeros into the DSP
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    c_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[27*i +: 27];
        b_sel = req_b[18*i +: 18];
        c_sel = req_c[48*i +: 48];
      end
    end
  end

  assign mac_a = a_sel;
  assign mac_b = b_sel;
  assign mac_c = c_dly_reg[C_SKEW-1];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr_reg <= '0;
    end else if (grant_any) begin
      rr_ptr_reg <= wrap_add(grant_idx, 1);
    end
  end

  // Addend delay line matching the DSP's internal skew between a/b and c
  generate
    for (genvar gi = 0; gi < C_SKEW; gi++) begin : g_cdly
      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          c_dly_reg[gi] <= '0;
        end else if (mac_ce) begin
          if (gi == 0) c_dly_reg[gi] <= c_sel;
          else         c_dly_reg[gi] <= c_dly_reg[(gi > 0) ? gi-1 : 0];
        end
      end
    end
  endgenerate

  // Tag pipeline runs in lockstep with the DSP registers
  generate
    for (genvar gi = 0; gi < MAC_LAT; gi++) begin : g_tag
      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          vld_reg[gi] <= 1'b0;
          id_reg[gi]  <= '0;
        end else if (mac_ce) begin
          if (gi == 0) begin
            vld_reg[gi] <= grant_any;
            id_reg[gi]  <= grant_idx;
          end else begin
            vld_reg[gi] <= vld_reg[(gi > 0) ? gi-1 : 0];
            id_reg[gi]  <= id_reg[(gi > 0) ? gi-1 : 0];
          end
        end
      end
    end
  endgenerate

  assign res_valid = vld_reg[MAC_LAT-1];
  assign res_id    = id_reg[MAC_LAT-1];
  assign res_data  = mac_dout;
  assign busy      = |vld_reg;

endmodule

// File: tb/tb_mac_share_sched.sv
// Bench for mac_share_sched: directed vectors, multi-cycle corner sequences and a
// randomized run against a queue-based reference model. Includes a 3-stage DSP model.
module tb_mac_share_sched;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            ap_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [27*N-1:0] req_a;
  logic [18*N-1:0] req_b;
  logic [48*N-1:0] req_c;
  logic            res_valid;
  logic            res_ready;
  logic [IDW-1:0]  res_id;
  logic [47:0]     res_data;
  logic            mac_ce;
  logic [26:0]     mac_a;
  logic [17:0]     mac_b;
  logic [47:0]     mac_c;
  logic [47:0]     mac_dout;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mac_share_sched #(.N_REQ(N), .ID_W(IDW), .MAC_LAT(3), .C_SKEW(1)) dut (
    .ap_clk(clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
    .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_dout(mac_dout), .busy(busy)
  );

  // External DSP: a/b captured at edge 1, addend joins at edge 2, sum out after edge 3
  logic signed [26:0] dsp_a1;
  logic signed [17:0] dsp_b1;
  logic signed [47:0] dsp_p2;
  logic        [47:0] dsp_c2;
  logic        [47:0] dsp_out;
  always_ff @(posedge clk) begin
    if (mac_ce) begin
      dsp_a1  <= mac_a;
      dsp_b1  <= mac_b;
      dsp_p2  <= 48'(dsp_a1) * 48'(dsp_b1);
      dsp_c2  <= mac_c;
      dsp_out <= dsp_p2 + dsp_c2;
    end
  end
  assign mac_dout = dsp_out;

  typedef struct {
    int          id;
    logic [26:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic [47:0] res;
  } vec_t;

  typedef struct {
    int          id;
    logic [47:0] data;
    int          due;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] exp_mac(input logic [26:0] a, input logic [17:0] b,
                                          input logic [47:0] c);
    longint r;
    r = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
    return r[47:0];
  endfunction

  task automatic set_req(input int i, input logic v, input logic [26:0] a,
                         input logic [17:0] b, input logic [47:0] c);
    req_valid[i]       = v;
    req_a[27*i +: 27]  = a;
    req_b[18*i +: 18]  = b;
    req_c[48*i +: 48]  = c;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    clear_reqs();
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 ap_rst = 1'b0;
    next_cycle();
  endtask

  // One op from v.id in cycle 0; result expected exactly in cycle 3, idle by cycle 4
  task automatic run_single(input vec_t v, input string tag);
    logic [3:0] onehot;
    onehot = 4'b0001 << v.id;
    set_req(v.id, 1'b1, v.a, v.b, v.c);
    @(negedge clk);
    check($sformatf("%s ready", tag), 64'(req_ready), 64'(onehot));
    check($sformatf("%s mac_a", tag), 64'(mac_a), 64'(v.a));
    next_cycle();
    set_req(v.id, 1'b0, '0, '0, '0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check($sformatf("%s mac_c", tag), 64'(mac_c), 64'(v.c));
      if (cyc == 3) begin
        check($sformatf("%s res_valid", tag), 64'(res_valid), 64'd1);
        check($sformatf("%s res_id", tag), 64'(res_id), 64'(v.id));
        check($sformatf("%s res_data", tag), 64'(res_data), 64'(v.res));
      end else begin
        check($sformatf("%s res_valid c%0d", tag, cyc), 64'(res_valid), 64'd0);
      end
      if (cyc == 4) check($sformatf("%s busy", tag), 64'(busy), 64'd0);
      next_cycle();
    end
  endtask

  vec_t vecs[6];
  exp_t mq[$];

  initial begin
    int order[3];
    int next_op, exp_res, k, ptr, adv, g;
    logic took, exp_valid, stall;
    logic [N-1:0] mgrant;
    logic [26:0] ra[N];
    logic [17:0] rb[N];
    logic [47:0] rc[N];
    exp_t e;

    vecs[0] = '{0, 27'd3,         18'h3FFFE, 48'd100,            48'd94};
    vecs[1] = '{2, 27'h4000000,   18'h20000, 48'h7FFF_FFFF_FFFF, 48'h87FF_FFFF_FFFF};
    vecs[2] = '{3, 27'd1,         18'd1,     48'd1,              48'd2};
    vecs[3] = '{1, 27'h7FFFFFF,   18'h3FFFF, 48'hFFFF_FFFF_FFFF, 48'd0};
    vecs[4] = '{2, 27'd1000,      18'h3FC18, 48'd0,              48'hFFFF_FFF0_BDC0};
    vecs[5] = '{0, 27'h3FFFFFF,   18'h1FFFF, 48'd0,              48'h07FF_FBFE_0001};

    // Reset state
    ap_rst = 1'b1;
    clear_reqs();
    res_ready = 1'b1;
    #2;
    check("rst res_valid", 64'(res_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst mac_ce", 64'(mac_ce), 64'd1);
    check("rst mac_c", 64'(mac_c), 64'd0);
    repeat (2) @(posedge clk);
    #3 ap_rst = 1'b0;
    next_cycle();

    // Table-driven single operations (entry 0 runs right after reset)
    foreach (vecs[i]) run_single(vecs[i], $sformatf("vec%0d", i));

    // Round-robin among requesters 0, 1, 3
    do_reset();
    order = '{0, 1, 3};
    foreach (order[i]) set_req(order[i], 1'b1, 27'(10 + order[i]), 18'd1, 48'd0);
    for (int cyc = 0; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc < 6) check($sformatf("rr grant c%0d", cyc), 64'(req_ready), 64'(4'b0001 << order[cyc % 3]));
      else         check($sformatf("rr grant c%0d", cyc), 64'(req_ready), 64'd0);
      if (cyc >= 3) begin
        check($sformatf("rr res_valid c%0d", cyc), 64'(res_valid), 64'd1);
        check($sformatf("rr res_id c%0d", cyc), 64'(res_id), 64'(order[(cyc - 3) % 3]));
        check($sformatf("rr res_data c%0d", cyc), 64'(res_data), 64'(10 + order[(cyc - 3) % 3]));
      end
      next_cycle();
      if (cyc == 5) clear_reqs();
    end

    // Backpressure on result 1 for four cycles
    do_reset();
    next_op = 0;
    exp_res = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (next_op < 5) set_req(2, 1'b1, 27'(next_op), 18'd1, 48'd0);
      else             set_req(2, 1'b0, '0, '0, '0);
      res_ready = !(cyc >= 4 && cyc <= 7);
      @(negedge clk);
      if (cyc >= 4 && cyc <= 7) begin
        check($sformatf("bp hold valid c%0d", cyc), 64'(res_valid), 64'd1);
        check($sformatf("bp hold data c%0d", cyc), 64'(res_data), 64'd1);
        check($sformatf("bp ready c%0d", cyc), 64'(req_ready), 64'd0);
        check($sformatf("bp mac_ce c%0d", cyc), 64'(mac_ce), 64'd0);
      end
      if (res_valid && res_ready) begin
        check($sformatf("bp res_data #%0d", exp_res), 64'(res_data), 64'(exp_res));
        check($sformatf("bp res_id #%0d", exp_res), 64'(res_id), 64'd2);
        exp_res++;
      end
      took = req_ready[2];
      next_cycle();
      if (took) next_op++;
    end
    res_ready = 1'b1;
    check("bp result count", 64'(exp_res), 64'd5);
    check("bp busy end", 64'(busy), 64'd0);

    // Asynchronous reset with three ops in flight
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 27'(i + 1), 18'd1, 48'd0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      check($sformatf("mid grant c%0d", cyc), 64'(req_ready), 64'(4'b0001 << cyc));
      if (cyc < 2) next_cycle();
    end
    check("mid busy before rst", 64'(busy), 64'd1);
    #2 ap_rst = 1'b1;
    clear_reqs();
    #1;
    check("mid res_valid", 64'(res_valid), 64'd0);
    check("mid busy", 64'(busy), 64'd0);
    check("mid mac_ce", 64'(mac_ce), 64'd1);
    repeat (2) @(posedge clk);
    #3 ap_rst = 1'b0;
    next_cycle();
    run_single(vecs[2], "post_rst");

    // Bubbles: requester 1 on even cycles only
    do_reset();
    for (int cyc = 0; cyc <= 10; cyc++) begin
      k = cyc / 2;
      if (cyc % 2 == 0 && cyc <= 6) set_req(1, 1'b1, 27'(k + 1), 18'd2, 48'(5 + k));
      else                          set_req(1, 1'b0, '0, '0, '0);
      @(negedge clk);
      if (cyc % 2 == 0 && cyc <= 6) begin
        check($sformatf("bub grant c%0d", cyc), 64'(req_ready), 64'd2);
        check($sformatf("bub mac_a c%0d", cyc), 64'(mac_a), 64'(k + 1));
      end else begin
        check($sformatf("bub grant c%0d", cyc), 64'(req_ready), 64'd0);
        check($sformatf("bub mac_a c%0d", cyc), 64'(mac_a), 64'd0);
      end
      if (cyc >= 1) begin
        if ((cyc - 1) % 2 == 0 && cyc - 1 <= 6)
          check($sformatf("bub mac_c c%0d", cyc), 64'(mac_c), 64'(5 + (cyc - 1) / 2));
        else
          check($sformatf("bub mac_c c%0d", cyc), 64'(mac_c), 64'd0);
      end
      if (cyc >= 3 && (cyc - 3) % 2 == 0 && cyc - 3 <= 6) begin
        check($sformatf("bub res_valid c%0d", cyc), 64'(res_valid), 64'd1);
        check($sformatf("bub res_data c%0d", cyc), 64'(res_data), 64'(3 * ((cyc - 3) / 2) + 7));
      end else begin
        check($sformatf("bub res_valid c%0d", cyc), 64'(res_valid), 64'd0);
      end
      next_cycle();
    end

    // Randomized traffic against a queue model: ops become visible MAC_LAT unstalled cycles after issue
    do_reset();
    ptr = 0;
    adv = 0;
    mgrant = '0;
    mq.delete();
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; rb[i] = '0; rc[i] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || mgrant[i]) begin
          if ($urandom_range(0, 9) < 6) begin
            ra[i] = 27'($urandom);
            rb[i] = 18'($urandom);
            rc[i] = {16'($urandom), 32'($urandom)};
            set_req(i, 1'b1, ra[i], rb[i], rc[i]);
          end else begin
            set_req(i, 1'b0, ra[i], rb[i], rc[i]);
          end
        end else if ($urandom_range(0, 9) == 0) begin
          set_req(i, 1'b0, ra[i], rb[i], rc[i]);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_valid = (mq.size() > 0) && (mq[0].due <= adv);
      stall = exp_valid && !res_ready;
      mgrant = '0;
      g = -1;
      if (!stall) begin
        for (int j = 0; j < N; j++) begin
          if (g < 0 && req_valid[(ptr + j) % N]) g = (ptr + j) % N;
        end
      end
      if (g >= 0) mgrant[g] = 1'b1;
      check($sformatf("rnd ready c%0d", cyc), 64'(req_ready), 64'(mgrant));
      check($sformatf("rnd res_valid c%0d", cyc), 64'(res_valid), 64'(exp_valid));
      check($sformatf("rnd mac_ce c%0d", cyc), 64'(mac_ce), 64'(!stall));
      check($sformatf("rnd busy c%0d", cyc), 64'(busy), 64'(mq.size() > 0));
      if (exp_valid) begin
        check($sformatf("rnd res_id c%0d", cyc), 64'(res_id), 64'(mq[0].id));
        check($sformatf("rnd res_data c%0d", cyc), 64'(res_data), 64'(mq[0].data));
        if (res_ready) void'(mq.pop_front());
      end
      if (g >= 0) begin
        e.id   = g;
        e.data = exp_mac(ra[g], rb[g], rc[g]);
        e.due  = adv + 3;
        mq.push_back(e);
        ptr = (g + 1) % N;
      end
      if (!stall) adv++;
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_share_sched.md
Name: mac_share_sched

Overview:
- Time-shares one external pipelined multiply-add DSP (signed 27x18 product plus 48-bit addend, 3 register stages, ce-gated) among N_REQ requesters.
- Round-robin arbiter: issues at most one operation per cycle.
- Aligns the addend to the DSP's internal skew and tags each in-flight operation with its requester id.
- Returns results on one valid/ready bus; stalls the whole DSP pipeline through mac_ce under backpressure.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of res_id, equal to clog2(N_REQ)
MAC_LAT, 3, clock edges from operand capture to result on mac_dout
C_SKEW, 1, cycles the addend is presented after its a/b operands

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  per-requester operation valid
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
req_a  in  27*N_REQ  signed multiplicand, requester i at bits [27i+26:27i]
req_b  in  18*N_REQ  signed multiplier, packed the same way
req_c  in  48*N_REQ  signed addend, packed the same way
res_valid  out  1  result valid
res_ready  in  1  downstream accept
res_id  out  ID_W  requester index of the result
res_data  out  48  a*b+c, two's complement, wraps modulo 2^48
mac_ce  out  1  DSP clock enable
mac_a  out  27  DSP din0
mac_b  out  18  DSP din1
mac_c  out  48  DSP din2
mac_dout  in  48  DSP dout
busy  out  1  any operation in flight

Behaviour:
- stall = res_valid & ~res_ready. mac_ce = ~stall.
- Arbitration (combinational): when ~stall, grant the first i with req_valid[i], scanning from rr_ptr upward modulo N_REQ. req_ready = grant.
- Issue handshake: req_valid[i] & req_ready[i].
- A requester holds valid and operands until ready. A requester may deassert valid without being served; no error results.
- rr_ptr: reset 0. On issue from i, rr_ptr <= (i+1) mod N_REQ. Otherwise it holds.
- mac_a/mac_b = operands of the granted requester. They are 0 when there is no grant; the cycle is then a bubble and the DSP still clocks.
- c_dly register: on each mac_ce edge, loads the granted req_c, or 0 on a bubble. mac_c = c_dly. This gives C_SKEW=1.
- Tag pipeline, MAC_LAT stages of {vld, id}, advances only when mac_ce=1.
  - Stage 0 loads {issue, grant index}.
  - res_valid = last-stage vld; res_id = last-stage id.
  - res_data = mac_dout, passed through unregistered.
- Latency: an op issued in cycle t appears with res_valid in cycle t+MAC_LAT, absent stalls. Each stall cycle adds one. Throughput is one op per cycle.
- While stalled:
  - DSP, c_dly, tag pipeline and rr_ptr are frozen.
  - req_ready = 0.
  - res_valid, res_id and res_data hold stable until res_ready.
- Results return in issue order; none are dropped or duplicated.
- busy = OR of all tag vld bits.
- Reset (asynchronous, any time, including mid-flight):
  - All tag vld bits cleared, so res_valid=0 and busy=0.
  - rr_ptr=0 and c_dly=0.
  - mac_ce=1, req_ready follows arbitration.
  - In-flight operations are discarded. DSP data registers are not reset; their stale contents are masked by the cleared vld bits.
- Simultaneous requests: exactly one grant per cycle. A continuously requesting requester waits at most N_REQ-1 issue cycles.
- Simultaneous result accept and new issue in the same cycle is allowed, since stall=0 in that cycle.

Test Plan:
1. Single op: reset, then req 0 with a=3, b=-2, c=100 for one cycle -> req_ready[0]=1 at cycle 0; res_valid=1 exactly at cycle 3 with res_id=0, res_data=94; busy=0 at cycle 4.
2. Round-robin: req 0, 1 and 3 valid continuously, res_ready=1 -> grant order 0,1,3,0,1,3; results in the same order, one per cycle starting 3 cycles after the first grant.
3. Backpressure: stream 5 ops from req 2 with a=i, b=1, c=0; drop res_ready for 4 cycles while result 1 is valid -> res_data holds 1 stable; req_ready=0 and mac_ce=0 during the stall; outputs then 2,3,4 with none lost.
4. Reset mid-flight: issue 3 ops, assert ap_rst asynchronously between clock edges before any result -> res_valid and busy fall immediately; after release, a new op (a=1, b=1, c=1) from req 3 returns 2 with id 3 and no stale results.
5. Width/wrap: a=-2^26, b=-2^17, c=2^47-1 -> res_data = (2^43 + 2^47 - 1) mod 2^48 as two's complement, i.e. 0x87FFFFFFFFFF.
6. Bubbles: req 1 valid only on alternating cycles -> results at matching alternating cycles with res_valid=0 between them; mac_c=0 on bubble cycles.
